// File: rtl/instr_sequencer_if.sv
// Command/operand handshake streams and instruction-bus outputs of the instruction sequencer.
interface instr_sequencer_if #(
    parameter int unsigned ADDR_W = 15,
    parameter int unsigned CNT_W  = 8
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [2:0]        cmd_op;
    logic [ADDR_W-1:0] cmd_addr;
    logic [CNT_W-1:0]  cmd_count;
    logic              dat_valid;
    logic              dat_ready;
    logic [15:0]       dat_in;
    logic [63:0]       instruction;
    logic              busy;
    logic              done;
    logic              err;

    modport master (
        output cmd_valid, cmd_op, cmd_addr, cmd_count, dat_valid, dat_in,
        input  cmd_ready, dat_ready, instruction, busy, done, err
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_addr, cmd_count, dat_valid, dat_in,
        output cmd_ready, dat_ready, instruction, busy, done, err
    );
endinterface

// File: rtl/instr_sequencer.sv
// Expands host commands into one encoded 64-bit array-controller instruction per cycle.
// All bus outputs are registered and describe the state entered on the same edge.
module instr_sequencer #(
    parameter int unsigned ADDR_W   = 15,
    parameter int unsigned CNT_W    = 8,
    parameter int unsigned MAC_WAIT = 8
) (
    input logic              clk,
    input logic              rst,
    instr_sequencer_if.slave bus
);
    localparam int unsigned WAIT_W = $clog2(MAC_WAIT + 1) + 1;

    localparam logic [4:0] OP_NOP    = 5'b11111;
    localparam logic [4:0] OP_MAC    = 5'b00001;
    localparam logic [4:0] OP_SENDW  = 5'b00010;
    localparam logic [4:0] OP_STORE  = 5'b00011;
    localparam logic [4:0] OP_RECVI  = 5'b00100;
    localparam logic [4:0] OP_RECVW  = 5'b00101;
    localparam logic [4:0] OP_XMIT   = 5'b00110;
    localparam logic [4:0] OP_RSTACC = 5'b00111;

    localparam logic [2:0] CMD_LOAD_INP = 3'd0;
    localparam logic [2:0] CMD_LOAD_WT  = 3'd1;
    localparam logic [2:0] CMD_RUN      = 3'd2;
    localparam logic [2:0] CMD_STORE    = 3'd3;
    localparam logic [2:0] CMD_XMIT     = 3'd4;

    localparam logic [63:0] IDLE_WORD = 64'h0;
    localparam logic [63:0] NOP_WORD  = {OP_NOP, 59'b0};

    typedef enum logic [3:0] {
        S_IDLE, S_LOAD, S_RUN_RST, S_RUN_WT, S_RUN_MAC,
        S_RUN_WAIT, S_RUN_STORE, S_OUTSEQ, S_FIN
    } state_t;

    function automatic logic [63:0] enc(input logic [4:0] opc, input logic [15:0] addr,
                                        input logic [15:0] data);
        return {opc, addr, data, 27'b0};
    endfunction

    state_t            state;
    state_t            next_state;
    logic [2:0]        op_q;
    logic [ADDR_W-1:0] base_q;
    logic [CNT_W-1:0]  count_q;
    logic [CNT_W-1:0]  idx_q;
    logic [CNT_W-1:0]  idx_d;
    logic [WAIT_W-1:0] wait_q;
    logic [WAIT_W-1:0] wait_d;
    logic [63:0]       instr_q;
    logic [63:0]       instr_d;
    logic              cmd_ready_q;
    logic              dat_ready_q;
    logic              busy_q;
    logic              done_q;
    logic              err_q;
    logic              err_set;

    logic              accept;
    logic              hs;
    logic [CNT_W-1:0]  count_sel;
    logic [ADDR_W-1:0] load_addr;
    logic [3:0]        out_nib;
    logic [4:0]        load_opc;
    logic [4:0]        out_opc;
    logic [4:0]        acc_out_opc;
    logic              next_open;

    assign accept      = bus.cmd_valid & cmd_ready_q;
    assign hs          = bus.dat_valid & dat_ready_q;
    assign count_sel   = accept ? bus.cmd_count : count_q;
    assign load_addr   = base_q + ADDR_W'(idx_q);
    assign out_nib     = base_q[3:0] + idx_q[3:0];
    assign load_opc    = (op_q == CMD_LOAD_WT) ? OP_RECVW : OP_RECVI;
    assign out_opc     = (op_q == CMD_XMIT) ? OP_XMIT : OP_STORE;
    assign acc_out_opc = (bus.cmd_op == CMD_XMIT) ? OP_XMIT : OP_STORE;
    assign next_open   = (next_state == S_IDLE) || (next_state == S_FIN);

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= next_state;
    end

    // Next state plus the word the bus will carry in that state.
    always_comb begin
        next_state = state;
        instr_d    = NOP_WORD;
        idx_d      = idx_q;
        wait_d     = wait_q;
        err_set    = 1'b0;
        case (state)
            S_IDLE, S_FIN: begin
                next_state = S_IDLE;
                instr_d    = IDLE_WORD;
                if (accept) begin
                    idx_d  = '0;
                    wait_d = '0;
                    case (bus.cmd_op)
                        CMD_LOAD_INP, CMD_LOAD_WT: begin
                            if (bus.cmd_count != '0) begin
                                next_state = S_LOAD;
                                instr_d    = NOP_WORD;
                            end else begin
                                next_state = S_FIN;
                            end
                        end
                        CMD_RUN: begin
                            next_state = S_RUN_RST;
                            instr_d    = enc(OP_RSTACC, 16'h0, 16'h0);
                        end
                        CMD_STORE, CMD_XMIT: begin
                            if (bus.cmd_count != '0) begin
                                next_state = S_OUTSEQ;
                                instr_d    = enc(acc_out_opc, 16'(bus.cmd_addr[3:0]), 16'h0);
                                idx_d      = CNT_W'(1);
                            end else begin
                                next_state = S_FIN;
                            end
                        end
                        default: begin
                            next_state = S_FIN;
                            err_set    = 1'b1;
                        end
                    endcase
                end
            end
            S_LOAD: begin
                if (hs) begin
                    instr_d = enc(load_opc, 16'(load_addr), bus.dat_in);
                    idx_d   = idx_q + CNT_W'(1);
                end else if (idx_q == count_q) begin
                    next_state = S_FIN;
                    instr_d    = IDLE_WORD;
                end
            end
            S_RUN_RST: begin
                next_state = S_RUN_WT;
                instr_d    = enc(OP_SENDW, 16'h0, 16'h0);
            end
            S_RUN_WT: begin
                next_state = S_RUN_MAC;
                instr_d    = enc(OP_MAC, 16'h0, 16'h0);
            end
            S_RUN_MAC: begin
                if (MAC_WAIT == 0) begin
                    next_state = S_RUN_STORE;
                    instr_d    = enc(OP_STORE, 16'(base_q[3:0]), 16'h0);
                end else begin
                    next_state = S_RUN_WAIT;
                    wait_d     = WAIT_W'(1);
                end
            end
            S_RUN_WAIT: begin
                if (wait_q == WAIT_W'(MAC_WAIT)) begin
                    next_state = S_RUN_STORE;
                    instr_d    = enc(OP_STORE, 16'(base_q[3:0]), 16'h0);
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            S_RUN_STORE: begin
                next_state = S_FIN;
                instr_d    = IDLE_WORD;
            end
            S_OUTSEQ: begin
                if (idx_q == count_q) begin
                    next_state = S_FIN;
                    instr_d    = IDLE_WORD;
                end else begin
                    instr_d = enc(out_opc, 16'(out_nib), 16'h0);
                    idx_d   = idx_q + CNT_W'(1);
                end
            end
            default: begin
                next_state = S_IDLE;
                instr_d    = IDLE_WORD;
            end
        endcase
    end

    // Command fields, sequencing counters and registered bus outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q        <= '0;
            base_q      <= '0;
            count_q     <= '0;
            idx_q       <= '0;
            wait_q      <= '0;
            instr_q     <= IDLE_WORD;
            cmd_ready_q <= 1'b0;
            dat_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            if (accept) begin
                op_q    <= bus.cmd_op;
                base_q  <= bus.cmd_addr;
                count_q <= bus.cmd_count;
            end
            idx_q       <= idx_d;
            wait_q      <= wait_d;
            instr_q     <= instr_d;
            cmd_ready_q <= next_open;
            busy_q      <= !next_open;
            done_q      <= (next_state == S_FIN);
            dat_ready_q <= (next_state == S_LOAD) && (idx_d != count_sel);
            err_q       <= err_q | err_set;
        end
    end

    assign bus.instruction = instr_q;
    assign bus.cmd_ready   = cmd_ready_q;
    assign bus.dat_ready   = dat_ready_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.err         = err_q;
endmodule

// File: tb/tb_instr_sequencer.sv
// Cycle-accurate vector table for instr_sequencer (MAC_WAIT = 2) plus a hand-written STORE sequence.
module tb_instr_sequencer;
    typedef struct {
        logic        rst;
        logic        cv;
        logic [2:0]  op;
        logic [14:0] addr;
        logic [7:0]  cnt;
        logic        dv;
        logic [15:0] din;
        logic [63:0] instr;
        logic [4:0]  flags;  // {cmd_ready, dat_ready, busy, done, err}
    } vec_t;

    localparam logic [63:0] Z   = 64'h0;
    localparam logic [63:0] NOP = 64'hF800_0000_0000_0000;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    vec_t tbl[$];

    instr_sequencer_if #(.ADDR_W(15), .CNT_W(8)) bus ();

    instr_sequencer #(.ADDR_W(15), .CNT_W(8), .MAC_WAIT(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] w(input logic [4:0] o, input logic [15:0] a, input logic [15:0] d);
        return {o, a, d, 27'b0};
    endfunction

    task automatic add(input logic r, input logic cv, input logic [2:0] op, input logic [14:0] a,
                       input logic [7:0] c, input logic dv, input logic [15:0] d,
                       input logic [63:0] ins, input logic [4:0] fl);
        vec_t t;
        t.rst = r; t.cv = cv; t.op = op; t.addr = a; t.cnt = c;
        t.dv = dv; t.din = d; t.instr = ins; t.flags = fl;
        tbl.push_back(t);
    endtask

    task automatic chk(input string name, input logic [71:0] got, input logic [71:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic drive(input logic r, input logic cv, input logic [2:0] op, input logic [14:0] a,
                         input logic [7:0] c, input logic dv, input logic [15:0] d);
        rst = r; bus.cmd_valid = cv; bus.cmd_op = op; bus.cmd_addr = a;
        bus.cmd_count = c; bus.dat_valid = dv; bus.dat_in = d;
    endtask

    initial begin
        logic [63:0] words[$];
        logic        seen;
        logic [63:0] exp_w[3];
        logic [63:0] got_w;

        // Reset, then idle.
        add(1, 0, 0, 0, 0, 0, 0, Z, 5'b00000);
        add(1, 0, 0, 0, 0, 0, 0, Z, 5'b00000);
        add(0, 0, 0, 0, 0, 0, 0, Z, 5'b10000);
        // Reset during LOAD_INP count 4 after one word: abandoned, no done.
        add(0, 1, 0, 15'h0010, 4, 0, 0,        NOP,                        5'b01100);
        add(0, 0, 0, 0, 0, 1, 16'h1234,        w(5'b00100, 16'h0010, 16'h1234), 5'b01100);
        add(1, 0, 0, 0, 0, 0, 0,               Z,                          5'b00000);
        add(1, 0, 0, 0, 0, 0, 0,               Z,                          5'b00000);
        add(0, 0, 0, 0, 0, 0, 0,               Z,                          5'b10000);
        add(0, 0, 0, 0, 0, 0, 0,               Z,                          5'b10000);
        // LOAD_INP 0x7FFE count 3 with a dat_valid gap; address wraps to 0.
        add(0, 1, 0, 15'h7FFE, 3, 0, 0,        NOP,                        5'b01100);
        add(0, 0, 0, 0, 0, 1, 16'hAAAA,        w(5'b00100, 16'h7FFE, 16'hAAAA), 5'b01100);
        add(0, 0, 0, 0, 0, 0, 0,               NOP,                        5'b01100);
        add(0, 0, 0, 0, 0, 1, 16'hBBBB,        w(5'b00100, 16'h7FFF, 16'hBBBB), 5'b01100);
        add(0, 0, 0, 0, 0, 1, 16'hCCCC,        w(5'b00100, 16'h0000, 16'hCCCC), 5'b00100);
        add(0, 0, 0, 0, 0, 1, 16'hDDDD,        Z,                          5'b10010);
        add(0, 0, 0, 0, 0, 0, 0,               Z,                          5'b10000);
        // RUN addr 5: RstAcc, SendW, MAC, 2 NOPs, Store addr 5.
        add(0, 1, 2, 15'h0005, 9, 0, 0,        w(5'b00111, 16'h0, 16'h0),  5'b00100);
        add(0, 0, 0, 0, 0, 0, 0,               w(5'b00010, 16'h0, 16'h0),  5'b00100);
        add(0, 0, 0, 0, 0, 0, 0,               w(5'b00001, 16'h0, 16'h0),  5'b00100);
        add(0, 0, 0, 0, 0, 0, 0,               NOP,                        5'b00100);
        add(0, 0, 0, 0, 0, 0, 0,               NOP,                        5'b00100);
        add(0, 0, 0, 0, 0, 0, 0,               w(5'b00011, 16'h5, 16'h0),  5'b00100);
        add(0, 0, 0, 0, 0, 0, 0,               Z,                          5'b10010);
        add(0, 0, 0, 0, 0, 0, 0,               Z,                          5'b10000);
        // XMIT base 0xE count 4 with dat_valid held high: never consumed.
        add(0, 1, 4, 15'h000E, 4, 1, 16'hFFFF, w(5'b00110, 16'hE, 16'h0),  5'b00100);
        add(0, 0, 0, 0, 0, 1, 16'hFFFF,        w(5'b00110, 16'hF, 16'h0),  5'b00100);
        add(0, 0, 0, 0, 0, 1, 16'hFFFF,        w(5'b00110, 16'h0, 16'h0),  5'b00100);
        add(0, 0, 0, 0, 0, 1, 16'hFFFF,        w(5'b00110, 16'h1, 16'h0),  5'b00100);
        add(0, 0, 0, 0, 0, 1, 16'hFFFF,        Z,                          5'b10010);
        add(0, 0, 0, 0, 0, 1, 16'hFFFF,        Z,                          5'b10000);
        // Illegal op 6, then STORE count 0: sticky err, two done pulses, no instructions.
        add(0, 1, 6, 0, 0, 0, 0,               Z,                          5'b10011);
        add(0, 0, 0, 0, 0, 0, 0,               Z,                          5'b10001);
        add(0, 1, 3, 15'h0007, 0, 0, 0,        Z,                          5'b10011);
        add(0, 0, 0, 0, 0, 0, 0,               Z,                          5'b10001);
        // Back-to-back LOAD_WT count 1 then STORE count 1 with cmd_valid held.
        add(0, 1, 1, 15'h0020, 1, 0, 0,        NOP,                        5'b01101);
        add(0, 1, 1, 15'h0020, 1, 1, 16'h5A5A, w(5'b00101, 16'h0020, 16'h5A5A), 5'b00101);
        add(0, 1, 3, 15'h0003, 1, 0, 0,        Z,                          5'b10011);
        add(0, 1, 3, 15'h0003, 1, 0, 0,        w(5'b00011, 16'h3, 16'h0),  5'b00101);
        add(0, 0, 0, 0, 0, 0, 0,               Z,                          5'b10011);
        add(0, 0, 0, 0, 0, 0, 0,               Z,                          5'b10001);
        // Reset clears the sticky error.
        add(1, 0, 0, 0, 0, 0, 0,               Z,                          5'b00000);
        add(0, 0, 0, 0, 0, 0, 0,               Z,                          5'b10000);

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].rst, tbl[i].cv, tbl[i].op, tbl[i].addr, tbl[i].cnt, tbl[i].dv, tbl[i].din);
            @(posedge clk);
            #1;
            chk($sformatf("row%0d", i),
                {3'b0, bus.instruction, bus.cmd_ready, bus.dat_ready, bus.busy, bus.done, bus.err},
                {3'b0, tbl[i].instr, tbl[i].flags});
            #1;
        end

        // STORE base 0x3E count 3: collect words until done within a cycle budget.
        drive(0, 1, 3, 15'h003E, 3, 0, 0);
        @(posedge clk);
        #1;
        drive(0, 0, 0, 0, 0, 0, 0);
        seen = 1'b0;
        for (int k = 0; k < 12; k++) begin
            if (bus.done) begin
                seen = 1'b1;
                break;
            end
            words.push_back(bus.instruction);
            @(posedge clk);
            #1;
        end
        chk("seq_done_seen", 72'(seen), 72'(1));
        chk("seq_word_count", 72'(words.size()), 72'(3));
        chk("seq_done_flags", 72'({bus.instruction, bus.cmd_ready, bus.busy}),
            72'({64'h0, 1'b1, 1'b0}));
        exp_w[0] = w(5'b00011, 16'hE, 16'h0);
        exp_w[1] = w(5'b00011, 16'hF, 16'h0);
        exp_w[2] = w(5'b00011, 16'h0, 16'h0);
        for (int j = 0; j < 3; j++) begin
            got_w = (j < words.size()) ? words[j] : 64'hDEAD_DEAD_DEAD_DEAD;
            chk($sformatf("seq_word%0d", j), 72'(got_w), 72'(exp_w[j]));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
